// File: rtl/magnetron_scheduler.sv
// Magnetron power-stage sequencer: filament warm-up, time-proportioned HV duty
// cycling over a 7-tick window, enforced cooldown, and door/thermal interlocks.
module magnetron_scheduler #(
    parameter int TICK_DIV     = 100,
    parameter int WARMUP_TICKS = 3,
    parameter int COOL_TICKS   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cook_req,
    input  logic       door_sensor,
    input  logic       thermal_trip,
    input  logic [2:0] power_level,
    output logic       filament_en,
    output logic       hv_en,
    output logic       fan_en,
    output logic       fault,
    output logic       tick
);

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_WARMUP   = 3'd1,
        ST_RUN      = 3'd2,
        ST_COOLDOWN = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    localparam int PW   = $clog2(TICK_DIV);
    localparam int TMAX = (WARMUP_TICKS > COOL_TICKS) ? WARMUP_TICKS : COOL_TICKS;
    localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);

    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] WARM_LAST = TW'(WARMUP_TICKS - 1);
    localparam logic [TW-1:0] COOL_LAST = TW'(COOL_TICKS - 1);

    state_t          state_r;
    state_t          state_nx;
    logic [PW-1:0]   pre_r;
    logic [TW-1:0]   tcnt_r;
    logic [2:0]      win_r;
    logic [2:0]      pwr_q_r;
    logic            tick_s;
    logic            filament_en_r;
    logic            fan_en_r;
    logic            fault_r;

    assign tick_s = (state_r != ST_OFF) && (pre_r == PRE_LAST);

    // Next-state selection; thermal trip outranks door/request drop everywhere.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_OFF: begin
                if (cook_req && !door_sensor && !thermal_trip && (power_level != 3'd0)) begin
                    state_nx = ST_WARMUP;
                end else begin
                    state_nx = ST_OFF;
                end
            end
            ST_WARMUP: begin
                if (thermal_trip) begin
                    state_nx = ST_FAULT;
                end else if (door_sensor || !cook_req) begin
                    state_nx = ST_COOLDOWN;
                end else if (tick_s && (tcnt_r == WARM_LAST)) begin
                    state_nx = ST_RUN;
                end else begin
                    state_nx = ST_WARMUP;
                end
            end
            ST_RUN: begin
                if (thermal_trip) begin
                    state_nx = ST_FAULT;
                end else if (door_sensor || !cook_req) begin
                    state_nx = ST_COOLDOWN;
                end else begin
                    state_nx = ST_RUN;
                end
            end
            ST_COOLDOWN: begin
                if (thermal_trip) begin
                    state_nx = ST_FAULT;
                end else if (tick_s && (tcnt_r == COOL_LAST)) begin
                    state_nx = ST_OFF;
                end else begin
                    state_nx = ST_COOLDOWN;
                end
            end
            ST_FAULT: begin
                // The requester must drop before the fault can be left.
                if (!thermal_trip && !cook_req) begin
                    state_nx = ST_COOLDOWN;
                end else begin
                    state_nx = ST_FAULT;
                end
            end
            default: begin
                state_nx = ST_OFF;
            end
        endcase
    end

    // State register and registered decode of the slow driver outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_OFF;
            filament_en_r <= 1'b0;
            fan_en_r      <= 1'b0;
            fault_r       <= 1'b0;
        end else begin
            state_r       <= state_nx;
            filament_en_r <= (state_nx == ST_WARMUP) || (state_nx == ST_RUN);
            fan_en_r      <= (state_nx != ST_OFF);
            fault_r       <= (state_nx == ST_FAULT);
        end
    end

    // Prescaler, tick counter and duty window; all cleared on any state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_r   <= '0;
            tcnt_r  <= '0;
            win_r   <= 3'd0;
            pwr_q_r <= 3'd0;
        end else if (state_nx != state_r) begin
            pre_r  <= '0;
            tcnt_r <= '0;
            if (state_nx == ST_RUN) begin
                win_r   <= 3'd0;
                pwr_q_r <= power_level;
            end
        end else if (state_r == ST_OFF) begin
            pre_r  <= '0;
            tcnt_r <= '0;
        end else if (tick_s) begin
            pre_r <= '0;
            if ((state_r == ST_WARMUP) || (state_r == ST_COOLDOWN)) begin
                tcnt_r <= tcnt_r + 1'b1;
            end
            if (state_r == ST_RUN) begin
                // New power level is only adopted at the window boundary.
                if (win_r == 3'd6) begin
                    win_r   <= 3'd0;
                    pwr_q_r <= power_level;
                end else begin
                    win_r <= win_r + 3'd1;
                end
            end
        end else begin
            pre_r <= pre_r + 1'b1;
        end
    end

    assign hv_en       = (state_r == ST_RUN) && (win_r < pwr_q_r) && !door_sensor && !thermal_trip;
    assign filament_en = filament_en_r;
    assign fan_en      = fan_en_r;
    assign fault       = fault_r;
    assign tick        = tick_s;

endmodule

// File: tb/tb_magnetron_scheduler.sv
// Directed bench for magnetron_scheduler: per-cycle expected output vectors
// {tick, filament_en, hv_en, fan_en, fault} are queued with the stimulus and checked in order.
module tb_magnetron_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       cook_req;
    logic       door_sensor;
    logic       thermal_trip;
    logic [2:0] power_level;
    logic       filament_en;
    logic       hv_en;
    logic       fan_en;
    logic       fault;
    logic       tick;

    typedef struct {
        logic [4:0] v;
        string      tag;
    } exp_t;

    exp_t  sb[$];
    int    errors = 0;
    int    checks = 0;
    string cur_tag = "init";

    magnetron_scheduler #(
        .TICK_DIV(4),
        .WARMUP_TICKS(3),
        .COOL_TICKS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cook_req(cook_req),
        .door_sensor(door_sensor),
        .thermal_trip(thermal_trip),
        .power_level(power_level),
        .filament_en(filament_en),
        .hv_en(hv_en),
        .fan_en(fan_en),
        .fault(fault),
        .tick(tick)
    );

    always #5 clk = ~clk;

    function automatic void push(int n, logic [4:0] v);
        for (int i = 0; i < n; i++) begin
            sb.push_back('{v, cur_tag});
        end
    endfunction

    // n ticks of a steady state: three quiet cycles then the tick cycle
    function automatic void push_t(int n, logic [3:0] v);
        for (int i = 0; i < n; i++) begin
            push(3, {1'b0, v});
            push(1, {1'b1, v});
        end
    endfunction

    task automatic check_now(string tag, logic [4:0] expv);
        logic [4:0] obs;
        obs = {tick, filament_en, hv_en, fan_en, fault};
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check_now(e.tag, e.v);
        end
    endtask

    initial begin
        rst          = 1'b1;
        cook_req     = 1'b0;
        door_sensor  = 1'b0;
        thermal_trip = 1'b0;
        power_level  = 3'd0;
        #3;
        check_now("reset_state", 5'b00000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cur_tag = "off_idle";
        push(3, 5'b00000);
        drain();

        // power 3: 12 cycles warm-up, then 12 high / 16 low per window
        cook_req    = 1'b1;
        power_level = 3'd3;
        cur_tag = "warmup_p3";
        push_t(3, 4'b1010);
        cur_tag = "run_p3";
        push_t(3, 4'b1110);
        push_t(4, 4'b1010);
        push_t(3, 4'b1110);
        push_t(4, 4'b1010);
        drain();

        // mid-window change 3 -> 6 only applies from the next window
        cur_tag = "win0_p3";
        push_t(1, 4'b1110);
        drain();
        power_level = 3'd6;
        cur_tag = "win_keep_p3";
        push_t(2, 4'b1110);
        push_t(4, 4'b1010);
        cur_tag = "win_p6";
        push_t(6, 4'b1110);
        push_t(1, 4'b1010);
        drain();

        // door open with HV on: zero-cycle HV drop, cooldown ignores cook_req
        cur_tag = "p6_hv_on";
        push(2, 5'b01110);
        drain();
        door_sensor = 1'b1;
        #1;
        check_now("door_same_cycle", 5'b01010);
        cur_tag = "cooldown_door";
        push(1, 5'b00010);
        drain();
        door_sensor = 1'b0;
        cook_req    = 1'b0;
        push(2, 5'b00010);
        drain();
        cook_req = 1'b1;
        cur_tag = "cooldown_req_pulse";
        push(1, 5'b10010);
        drain();
        cook_req = 1'b0;
        cur_tag = "cooldown_door";
        push_t(1, 4'b0010);
        cur_tag = "off_after_door";
        push(3, 5'b00000);
        drain();

        // thermal trip in RUN, fault held while cook_req stays high
        cook_req    = 1'b1;
        power_level = 3'd3;
        cur_tag = "warmup_thermal";
        push_t(3, 4'b1010);
        push(2, 5'b01110);
        drain();
        thermal_trip = 1'b1;
        #1;
        check_now("thermal_same_cycle", 5'b01010);
        cur_tag = "fault_tripped";
        push(3, 5'b00011);
        drain();
        thermal_trip = 1'b0;
        cur_tag = "fault_req_held";
        push(1, 5'b10011);
        push_t(1, 4'b0011);
        drain();
        cook_req = 1'b0;
        cur_tag = "fault_cooldown";
        push_t(2, 4'b0010);
        cur_tag = "off_after_fault";
        push(2, 5'b00000);
        drain();

        // power 7: continuous HV across window wraps
        cook_req    = 1'b1;
        power_level = 3'd7;
        cur_tag = "warmup_p7";
        push_t(3, 4'b1010);
        cur_tag = "run_p7";
        push_t(15, 4'b1110);
        drain();
        cook_req = 1'b0;
        cur_tag = "cooldown_p7";
        push_t(2, 4'b0010);
        push(2, 5'b00000);
        drain();

        // power 0 request from OFF is ignored
        cook_req    = 1'b1;
        power_level = 3'd0;
        cur_tag = "p0_ignored";
        push(8, 5'b00000);
        drain();
        cook_req = 1'b0;

        // asynchronous reset mid-RUN with HV on
        power_level = 3'd3;
        cook_req    = 1'b1;
        cur_tag = "warmup_rst";
        push_t(3, 4'b1010);
        push(2, 5'b01110);
        drain();
        #2;
        rst = 1'b1;
        #1;
        check_now("rst_async_hv", 5'b00000);
        cook_req = 1'b0;
        cur_tag = "rst_held";
        push(2, 5'b00000);
        drain();
        rst = 1'b0;
        cur_tag = "off_after_rst";
        push(3, 5'b00000);
        drain();
        cook_req = 1'b1;
        cur_tag = "rerequest";
        push_t(1, 4'b1010);
        drain();
        cook_req = 1'b0;
        cur_tag = "cooldown_rerequest";
        push_t(2, 4'b0010);
        push(2, 5'b00000);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
